reg_file_wb_arbiter: RTL and testbench
======================================

Name: reg_file_wb_arbiter

Overview:
Shares the register file's single write port between two writeback sources: A (ALU/execute) and B (load unit). Each source uses a valid/ready handshake; one source is granted per cycle, and the granted write is registered onto the reg_file write port (rd, rd_v, we). A 32-entry pending-write scoreboard lets the issue stage mark destinations in flight and query whether operands are still pending. The block sits between the writeback sources, the issue stage and reg_file.

Parameters:
XLEN, 32, data width of writeback values and reg_file write data.
FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins when both are valid.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
a_valid  in  1  source A write request
a_ready  out  1  A request granted this cycle
a_rd  in  5  A destination register
a_data  in  XLEN  A write value
b_valid  in  1  source B write request
b_ready  out  1  B request granted this cycle
b_rd  in  5  B destination register
b_data  in  XLEN  B write value
mark_en  in  1  issue stage marks a destination pending
mark_rd  in  5  register to mark pending
q_rs1  in  5  query register 1
q_rs2  in  5  query register 2
q_rs1_busy  out  1  q_rs1 has a write outstanding
q_rs2_busy  out  1  q_rs2 has a write outstanding
rf_we  out  1  reg_file we
rf_rd  out  5  reg_file rd
rf_rd_v  out  XLEN  reg_file rd_v
pending  out  32  scoreboard vector; bit 0 is always 0
err  out  1  sticky protocol-error flag

Behaviour:
- Reset: rst_n is asynchronous and active-low; the clock is clk.
  - While rst_n is low: rf_we=0, rf_rd=0, rf_rd_v=0, pending=0, err=0, and the round-robin pointer is set to "last=B", so A wins first.
  - Asserting reset mid-operation drops any registered write (rf_we=0) and clears the whole scoreboard.
- Grant logic (combinational, from the valid inputs and the pointer):
  - Only A valid -> A granted. Only B valid -> B granted.
  - Both valid: if FIXED_PRIO=1, A is granted. If FIXED_PRIO=0, the source not granted last is granted.
  - The pointer updates only on a grant.
  - a_ready/b_ready equal the grants. They are never both 1, and a ready is never asserted without its valid.
  - A handshake completes on valid&&ready at the rising edge.
  - A source must hold valid, rd and data stable until its handshake completes.
- Write stage (registered, latency 1): a handshake at edge N drives rf_we/rf_rd/rf_rd_v during cycle N+1, and reg_file commits at edge N+1.
  - With no handshake, rf_we=0 the next cycle and rf_rd/rf_rd_v hold their previous values.
  - Sustained throughput is one write per cycle. There is no backpressure from reg_file.
- x0 writes: a request with rd=0 is handshaked normally, but rf_we stays 0. It still advances the round-robin pointer.
- Scoreboard:
  - At the edge where rf_we=1, pending[rf_rd] is cleared.
  - At an edge with mark_en=1 and mark_rd!=0, pending[mark_rd] is set.
  - Set and clear of the same index at the same edge: set wins, because the new producer takes ownership.
  - mark_rd=0 is ignored.
- Busy query (combinational): q_rsN_busy = pending[q_rsN]. It is always 0 for x0. A clear at the current edge is visible the following cycle; no bypass.
- err (sticky until reset) sets on either of:
  - a mark of an already-pending register that is not being cleared at the same edge;
  - a committed write (rf_we=1) to a register whose pending bit is 0.
- Only one outstanding writer per register is supported. The issue stage stalls on busy.

Test Plan:
- Reset: hold rst_n low with a_valid=b_valid=1 -> rf_we=0, pending=0, err=0. Release reset with both valid -> A is granted first (a_ready=1, b_ready=0).
- Round-robin: A and B continuously valid (A: rd=5, 0x11111111; B: rd=6, 0x22222222), FIXED_PRIO=0 -> grants alternate A,B,A,B. rf_we=1 every cycle from the cycle after the first grant, with rf_rd/rf_rd_v alternating 5/0x11111111, 6/0x22222222.
- Fixed priority: FIXED_PRIO=1 with both valid for 3 cycles, then A drops -> B is granted only in cycle 4. Its write appears on rf_* in cycle 5.
- Scoreboard: mark rd=7, then query q_rs1=7 -> busy=1. B writes rd=7, value 0xDEADBEEF -> rf_we in the next cycle, and q_rs1_busy=0 the cycle after commit. Readback through reg_file returns 0xDEADBEEF.
- x0 / same-edge: A writes rd=0 -> handshake completes, rf_we stays 0, err=0. Mark rd=9 at the same edge as the commit to rd=9 -> pending[9] stays 1 and err=0.
- Errors / mid-reset: mark rd=3 twice -> err=1. Pulse rst_n low while rf_we=1 -> rf_we=0 immediately, and pending and err are cleared.

Source files
------------

// File: rtl/reg_file_wb_arbiter.sv
// Writeback arbiter for the shared reg_file write port, with a 32-entry
// pending-write scoreboard used by issue for operand hazard queries.
module reg_file_wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            mark_en,
    input  logic [4:0]      mark_rd,
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    output logic            q_rs1_busy,
    output logic            q_rs2_busy,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_rd_v,
    output logic [31:0]     pending,
    output logic            err
);
    localparam int unsigned NREG = 32;
    localparam logic [NREG-1:0] X0_MASK = NREG'(1);

    logic            last_b_q, last_b_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_rd_v_q, rf_rd_v_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic            err_q, err_d;

    logic            grant_a, grant_b;
    logic            mark_ok;
    logic [NREG-1:0] clr_vec, set_vec;

    // Grant: a lone requester wins; on contention fixed priority or the source not served last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_valid && b_valid) begin
            if ((FIXED_PRIO != 0) || last_b_q) begin
                grant_a = 1'b1;
            end else begin
                grant_b = 1'b1;
            end
        end else begin
            grant_a = a_valid;
            grant_b = b_valid;
        end
    end

    // Next-state for the write stage, pointer, scoreboard and error flag.
    always_comb begin
        last_b_d  = last_b_q;
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_rd_v_d = rf_rd_v_q;
        clr_vec   = '0;
        set_vec   = '0;
        mark_ok   = mark_en && (mark_rd != 5'd0);

        if (grant_a) begin
            last_b_d  = 1'b0;
            rf_we_d   = (a_rd != 5'd0);
            rf_rd_d   = a_rd;
            rf_rd_v_d = a_data;
        end else if (grant_b) begin
            last_b_d  = 1'b1;
            rf_we_d   = (b_rd != 5'd0);
            rf_rd_d   = b_rd;
            rf_rd_v_d = b_data;
        end

        if (rf_we_q) begin
            clr_vec[rf_rd_q] = 1'b1;
        end
        if (mark_ok) begin
            set_vec[mark_rd] = 1'b1;
        end
        // Set after clear: a new producer owns the register even if the old one commits now.
        pending_d = ((pending_q & ~clr_vec) | set_vec) & ~X0_MASK;

        err_d = err_q
              | (mark_ok && pending_q[mark_rd] && !(rf_we_q && (rf_rd_q == mark_rd)))
              | (rf_we_q && !pending_q[rf_rd_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_q  <= 1'b1;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= 5'd0;
            rf_rd_v_q <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            last_b_q  <= last_b_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_rd_v_q <= rf_rd_v_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign rf_we      = rf_we_q;
    assign rf_rd      = rf_rd_q;
    assign rf_rd_v    = rf_rd_v_q;
    assign pending    = pending_q;
    assign err        = err_q;
    assign q_rs1_busy = pending_q[q_rs1];
    assign q_rs2_busy = pending_q[q_rs2];

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Scoreboard bench for reg_file_wb_arbiter: a reference model predicts each
// cycle's reg_file write, scoreboard and error state; a monitor compares.
module tb_reg_file_wb_arbiter;
    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            a_valid = 1'b0, b_valid = 1'b0, mark_en = 1'b0;
    logic [4:0]      a_rd = '0, b_rd = '0, mark_rd = '0, q_rs1 = '0, q_rs2 = '0;
    logic [XLEN-1:0] a_data = '0, b_data = '0;
    logic            a_ready, b_ready, q_rs1_busy, q_rs2_busy, rf_we, err;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_rd_v;
    logic [31:0]     pending;

    logic            fp_a_ready, fp_b_ready, fp_busy1, fp_busy2, fp_we, fp_err;
    logic [4:0]      fp_rd;
    logic [XLEN-1:0] fp_v;
    logic [31:0]     fp_pending;

    always #5 clk = ~clk;

    reg_file_wb_arbiter #(.XLEN(XLEN), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .mark_en(mark_en), .mark_rd(mark_rd), .q_rs1(q_rs1), .q_rs2(q_rs2),
        .q_rs1_busy(q_rs1_busy), .q_rs2_busy(q_rs2_busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_rd_v(rf_rd_v), .pending(pending), .err(err)
    );

    // Fixed-priority instance shares the inputs; only its grant is checked.
    reg_file_wb_arbiter #(.XLEN(XLEN), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(fp_a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(fp_b_ready), .b_rd(b_rd), .b_data(b_data),
        .mark_en(mark_en), .mark_rd(mark_rd), .q_rs1(q_rs1), .q_rs2(q_rs2),
        .q_rs1_busy(fp_busy1), .q_rs2_busy(fp_busy2),
        .rf_we(fp_we), .rf_rd(fp_rd), .rf_rd_v(fp_v), .pending(fp_pending), .err(fp_err)
    );

    typedef struct {
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pend;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    bit          m_last_a;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_pend;
    bit          m_err;
    int          last_g = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: one expected write-stage state per clock after reset.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                chk("idle_rf_we", 32'(rf_we), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rf_we", 32'(rf_we), 32'(e.we));
                chk("rf_rd", 32'(rf_rd), 32'(e.rd));
                chk("rf_rd_v", rf_rd_v, e.data);
                chk("pending", pending, e.pend);
                chk("err", 32'(err), 32'(e.err));
            end
        end
    end

    // One cycle: check combinational outputs, then advance the model at the edge.
    task automatic step();
        int g;
        logic [31:0] old_pend;
        exp_t e;
        #1;
        if (a_valid && b_valid) g = m_last_a ? 2 : 1;
        else if (a_valid)       g = 1;
        else if (b_valid)       g = 2;
        else                    g = 0;
        chk("a_ready", 32'(a_ready), 32'(g == 1));
        chk("b_ready", 32'(b_ready), 32'(g == 2));
        chk("fp_a_ready", 32'(fp_a_ready), 32'(a_valid));
        chk("fp_b_ready", 32'(fp_b_ready), 32'(b_valid && !a_valid));
        chk("q_rs1_busy", 32'(q_rs1_busy), 32'(q_rs1 != 0 && m_pend[q_rs1]));
        chk("q_rs2_busy", 32'(q_rs2_busy), 32'(q_rs2 != 0 && m_pend[q_rs2]));
        @(posedge clk);
        old_pend = m_pend;
        if (mark_en && mark_rd != 0 && old_pend[mark_rd] && !(m_we && m_rd == mark_rd)) m_err = 1;
        if (m_we && !old_pend[m_rd]) m_err = 1;
        if (m_we) m_pend[m_rd] = 1'b0;
        if (mark_en && mark_rd != 0) m_pend[mark_rd] = 1'b1;
        if (g == 1) begin
            m_last_a = 1; m_we = (a_rd != 0); m_rd = a_rd; m_data = a_data;
        end else if (g == 2) begin
            m_last_a = 0; m_we = (b_rd != 0); m_rd = b_rd; m_data = b_data;
        end else begin
            m_we = 0;
        end
        e.we = m_we; e.rd = m_rd; e.data = m_data; e.pend = m_pend; e.err = m_err;
        exp_q.push_back(e);
        last_g = g;
        @(negedge clk);
    endtask

    // Reset pulse issued just after a falling edge; checks the async clear.
    task automatic do_reset(input int hold);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_rd", 32'(rf_rd), 32'd0);
        chk("rst_rf_rd_v", rf_rd_v, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        exp_q.delete();
        m_last_a = 0; m_we = 0; m_rd = '0; m_data = '0; m_pend = '0; m_err = 0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0; mark_en = 0;
    endtask

    initial begin
        // Reset with both sources requesting; A must win first.
        a_valid = 1; a_rd = 5'd5; a_data = 32'h11111111;
        b_valid = 1; b_rd = 5'd6; b_data = 32'h22222222;
        do_reset(2);
        repeat (6) step();

        // Scoreboard: mark 7, query it, B writes 0xDEADBEEF to 7.
        do_reset(1);
        idle(); mark_en = 1; mark_rd = 5'd7; step();
        idle(); q_rs1 = 5'd7; step();
        b_valid = 1; b_rd = 5'd7; b_data = 32'hDEADBEEF; step();
        idle(); step();
        step();

        // x0 write, then same-edge mark of a committing register.
        a_valid = 1; a_rd = 5'd0; a_data = 32'hA5A5A5A5; step();
        idle(); mark_en = 1; mark_rd = 5'd9; q_rs2 = 5'd9; step();
        idle(); a_valid = 1; a_rd = 5'd9; a_data = 32'h99; step();
        idle(); mark_en = 1; mark_rd = 5'd9; step();
        idle(); step();

        // Double mark sets err; reset while a write is on the port.
        mark_en = 1; mark_rd = 5'd3; step();
        step();
        idle(); a_valid = 1; a_rd = 5'd10; a_data = 32'h1010; step();
        idle();
        do_reset(1);

        // Randomized traffic with periodic resets.
        last_g = 0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 60 == 59) do_reset(1 + int'($urandom_range(2)));
            if (!a_valid || last_g == 1) begin
                a_valid = ($urandom_range(2) != 0);
                a_rd = 5'($urandom_range(12));
                a_data = $urandom;
            end
            if (!b_valid || last_g == 2) begin
                b_valid = ($urandom_range(2) != 0);
                b_rd = 5'($urandom_range(12));
                b_data = $urandom;
            end
            mark_en = ($urandom_range(3) == 0);
            mark_rd = 5'($urandom_range(12));
            q_rs1 = 5'($urandom_range(12));
            q_rs2 = 5'($urandom_range(12));
            step();
        end
        idle();
        step();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
